// File: rtl/i2s_tx.sv
// ---------------------------------------------------------------------------
// i2s_tx : I2S transmitter, word-select master.
//
// Serialises stereo L/R sample pairs onto ws_o/sdata_o, MSB first, with the
// standard one-bit I2S delay after each ws_o transition. Every flop updates on
// the falling edge of sclk_i, so the receiver samples sdata_o on the rising
// edge. Pairs are accepted through a one-entry valid/ready holding buffer and
// moved into the frame register on the "load edge" (frame counter wrapping
// from 2*SLOT-1 to 0).
//
// Parameters:
//   WIDTH  sample width in bits (two's complement)
//   SLOT   bits per channel slot (SLOT >= WIDTH, SLOT >= 2)
//
// Ports:
//   sclk_i        bit clock, state changes on its falling edge
//   rst_i         asynchronous active-low reset
//   leftChan_i    left sample
//   rightChan_i   right sample
//   valid_i       L/R pair present on the sample inputs
//   ready_o       holding buffer empty, a pair can be accepted
//   ws_o          word select: 0 = left slot, 1 = right slot
//   sdata_o       serial data, MSB first
//   frameStart_o  one-cycle pulse on the first cycle of each frame
//   underrun_o    one-cycle pulse when a frame loads with the buffer empty
//
// Build option:
//   I2S_TX_REPEAT_ON_UNDERRUN_EN  defined   : an underrun frame repeats the
//                                             previous pair
//                                 undefined : an underrun frame is silence
// ---------------------------------------------------------------------------
module i2s_tx #(
    parameter int WIDTH = 16,
    parameter int SLOT  = 16
) (
    input  logic             sclk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] leftChan_i,
    input  logic [WIDTH-1:0] rightChan_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             ws_o,
    output logic             sdata_o,
    output logic             frameStart_o,
    output logic             underrun_o
);

    localparam int            FRAME    = 2 * SLOT;
    localparam int            CW       = $clog2(FRAME);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);
    localparam logic [CW-1:0] SLOT_CNT = CW'(SLOT);

    generate
        if (SLOT < WIDTH || SLOT < 2) begin : gBadParams
            $error("i2s_tx: SLOT must be >= WIDTH and >= 2");
        end
    endgenerate

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_bufLeft;
    logic [WIDTH-1:0] r_bufRight;
    logic             r_bufFull;
    logic [FRAME-1:0] r_frame;
    logic             r_ws;
    logic             r_sdata;
    logic             r_frameStart;
    logic             r_underrun;

    logic             w_loadEdge;
    logic [CW-1:0]    w_cntNext;
    logic [CW-1:0]    w_bitIdx;
    logic [SLOT-1:0]  w_leftSlot;
    logic [SLOT-1:0]  w_rightSlot;

    assign w_loadEdge = (r_cnt == LAST_CNT);
    assign w_cntNext  = w_loadEdge ? '0 : r_cnt + CW'(1);

    // Serial bit s_k lives at F[FRAME-1-k]. The bit driven on the edge that
    // leaves cnt = k is s_k, which gives the one-bit delay and, on the load
    // edge, sends the previous frame's last bit before F is replaced.
    assign w_bitIdx = LAST_CNT - r_cnt;

    // Samples are MSB-justified in their slots with zero fill below.
    assign w_leftSlot  = SLOT'(r_bufLeft)  << (SLOT - WIDTH);
    assign w_rightSlot = SLOT'(r_bufRight) << (SLOT - WIDTH);

    always_ff @(negedge sclk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt        <= LAST_CNT;
            r_bufLeft    <= '0;
            r_bufRight   <= '0;
            r_bufFull    <= 1'b0;
            r_frame      <= '0;
            r_ws         <= 1'b1;
            r_sdata      <= 1'b0;
            r_frameStart <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_cnt        <= w_cntNext;
            r_ws         <= (w_cntNext >= SLOT_CNT);
            r_sdata      <= r_frame[w_bitIdx];
            r_frameStart <= w_loadEdge;
            r_underrun   <= w_loadEdge && !r_bufFull;

            if (w_loadEdge) begin
                if (r_bufFull) begin
                    r_frame   <= {w_leftSlot, w_rightSlot};
                    r_bufFull <= 1'b0;
                end else begin
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
                    r_frame <= r_frame;
`else
                    r_frame <= '0;
`endif
                end
            end

            // A full buffer blocks capture, so this never collides with the
            // emptying above; a pair arriving on an underrun load edge waits
            // in the buffer for the following frame.
            if (valid_i && !r_bufFull) begin
                r_bufLeft  <= leftChan_i;
                r_bufRight <= rightChan_i;
                r_bufFull  <= 1'b1;
            end
        end
    end

    assign ready_o      = !r_bufFull;
    assign ws_o         = r_ws;
    assign sdata_o      = r_sdata;
    assign frameStart_o = r_frameStart;
    assign underrun_o   = r_underrun;

endmodule

// File: tb/tb_i2s_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx : self-checking bench for i2s_tx.
//
// Two instances share the clock, reset and handshake: a 16/16 instance and a
// 12/16 instance fed with the upper 12 bits of each sample, so slot padding
// is exercised on every frame. A frame-level model predicts, for each load
// edge, which pair (or underrun filler) is transmitted and pushes it into a
// scoreboard queue; a monitor keyed on frameStart_o pops it and checks the
// serial bits, ws_o and underrun_o of both instances.
// ---------------------------------------------------------------------------
module tb_i2s_tx;

    localparam int          FRAME    = 32;
    localparam int          SLOT     = 16;
    localparam logic [31:0] PAD_MASK = 32'hFFF0_FFF0;

    logic        sclk_i;
    logic        rst_i;
    logic [15:0] leftChan;
    logic [15:0] rightChan;
    logic        valid;
    logic        ready, ws, sdata, frameStart, underrun;
    logic        padReady, padWs, padSdata, padFrameStart, padUnderrun;

    int checks = 0;
    int errors = 0;

    i2s_tx #(.WIDTH(16), .SLOT(16)) dut (
        .sclk_i       (sclk_i),
        .rst_i        (rst_i),
        .leftChan_i   (leftChan),
        .rightChan_i  (rightChan),
        .valid_i      (valid),
        .ready_o      (ready),
        .ws_o         (ws),
        .sdata_o      (sdata),
        .frameStart_o (frameStart),
        .underrun_o   (underrun)
    );

    i2s_tx #(.WIDTH(12), .SLOT(16)) dutPad (
        .sclk_i       (sclk_i),
        .rst_i        (rst_i),
        .leftChan_i   (leftChan[15:4]),
        .rightChan_i  (rightChan[15:4]),
        .valid_i      (valid),
        .ready_o      (padReady),
        .ws_o         (padWs),
        .sdata_o      (padSdata),
        .frameStart_o (padFrameStart),
        .underrun_o   (padUnderrun)
    );

    initial sclk_i = 1'b0;
    always #5 sclk_i = ~sclk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Frame-level reference model: a pair is transmitted in the first frame
    // whose load edge finds it buffered; otherwise the frame is filler.
    typedef struct {
        logic [31:0] frame;
        bit          underrun;
    } frameT;

    frameT       expQ[$];
    int          edgeNo;
    bit          mFull;
    logic [15:0] mLeft, mRight;
    logic [31:0] mLast;

    always @(negedge sclk_i or negedge rst_i) begin
        bit    readyBefore;
        frameT f;
        if (!rst_i) begin
            edgeNo = 0;
            mFull  = 1'b0;
            mLast  = '0;
            expQ.delete();
        end else begin
            readyBefore = !mFull;
            if (edgeNo % FRAME == 0) begin
                if (mFull) begin
                    f.frame    = {mLeft, mRight};
                    f.underrun = 1'b0;
                    mFull      = 1'b0;
                end else begin
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
                    f.frame = mLast;
`else
                    f.frame = '0;
`endif
                    f.underrun = 1'b1;
                end
                mLast = f.frame;
                expQ.push_back(f);
            end
            if (valid && readyBefore) begin
                mLeft  = leftChan;
                mRight = rightChan;
                mFull  = 1'b1;
            end
            edgeNo++;
        end
    end

    // Monitor: samples on the rising edge, half a cycle after outputs move.
    frameT       cur;
    logic [31:0] padFrame;
    bit          haveCur;
    bit          started;
    int          k;
    int          framesSeen = 0;

    always @(posedge sclk_i) begin
        if (!rst_i) begin
            haveCur = 1'b0;
            started = 1'b0;
            k       = 0;
        end else begin
            checkOutput("ready_o", ready, !mFull);
            checkOutput("pad ready_o", padReady, !mFull);
            checkOutput("pad frameStart_o", padFrameStart, frameStart);
            if (frameStart) begin
                if (started) checkOutput("frame period", k, FRAME - 1);
                checkOutput("sdata_o right LSB", sdata, haveCur ? cur.frame[0] : 1'b0);
                checkOutput("pad sdata_o right LSB", padSdata, 1'b0);
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected frameStart_o: got 1, expected no frame at %0t", $time);
                    haveCur = 1'b0;
                end else begin
                    cur      = expQ.pop_front();
                    padFrame = cur.frame & PAD_MASK;
                    haveCur  = 1'b1;
                    framesSeen++;
                    checkOutput("underrun_o", underrun, cur.underrun);
                    checkOutput("pad underrun_o", padUnderrun, cur.underrun);
                    checkOutput("ws_o at cnt 0", ws, 1'b0);
                    checkOutput("pad ws_o at cnt 0", padWs, 1'b0);
                end
                k       = 0;
                started = 1'b1;
            end else if (started) begin
                k++;
                if (k > FRAME - 1) begin
                    checkOutput("frame period", k, FRAME - 1);
                    started = 1'b0;
                end else if (haveCur) begin
                    checkOutput("sdata_o", sdata, cur.frame[FRAME - k]);
                    checkOutput("pad sdata_o", padSdata, padFrame[FRAME - k]);
                    checkOutput("ws_o", ws, k >= SLOT);
                    checkOutput("pad ws_o", padWs, k >= SLOT);
                    checkOutput("underrun_o mid-frame", underrun, 1'b0);
                end
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge sclk_i);
    endtask

    // Presents a pair once ready_o is seen high at a rising edge; the capture
    // then happens on the following falling edge.
    task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r,
                                 input bit hold);
        int guard = 0;
        while (ready !== 1'b1 && guard < 200) begin
            @(posedge sclk_i);
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL handshake timeout: ready_o=%b, expected 1 within 200 cycles", ready);
        end
        leftChan  = l;
        rightChan = r;
        valid     = 1'b1;
        @(posedge sclk_i);
        if (!hold) valid = 1'b0;
    endtask

    // Presents a pair so that it is captured on a load edge with the buffer
    // empty.
    task automatic applyAtLoadEdge(input logic [15:0] l, input logic [15:0] r);
        int guard = 0;
        while (!((edgeNo % FRAME == 0) && !mFull) && guard < 200) begin
            @(posedge sclk_i);
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL load-edge wait timeout: got no empty load edge, expected one within 200 cycles");
        end
        leftChan  = l;
        rightChan = r;
        valid     = 1'b1;
        @(posedge sclk_i);
        valid = 1'b0;
    endtask

    task automatic checkReset();
        checkOutput("reset ws_o", ws, 1'b1);
        checkOutput("reset sdata_o", sdata, 1'b0);
        checkOutput("reset ready_o", ready, 1'b1);
        checkOutput("reset frameStart_o", frameStart, 1'b0);
        checkOutput("reset underrun_o", underrun, 1'b0);
        checkOutput("pad reset ws_o", padWs, 1'b1);
        checkOutput("pad reset ready_o", padReady, 1'b1);
    endtask

    initial begin
        valid     = 1'b0;
        leftChan  = '0;
        rightChan = '0;
        rst_i     = 1'b0;
        repeat (2) @(posedge sclk_i);
        #1 checkReset();
        #1 rst_i = 1'b1;
        @(posedge sclk_i);

        $display("[TB] single pair");
        waitCycles(3);
        applyStimulus(16'hA5F0, 16'h0F0F, 1'b0);
        waitCycles(80);

        $display("[TB] padding pair");
        applyStimulus(16'h8005, 16'h7FF3, 1'b0);
        waitCycles(70);

        $display("[TB] write on load edge");
        applyAtLoadEdge(16'h1234, 16'hFEDC);
        waitCycles(70);

        $display("[TB] mid-frame reset");
        waitCycles(7);
        #2 rst_i = 1'b0;
        #1 checkReset();
        repeat (3) @(posedge sclk_i);
        #2 rst_i = 1'b1;
        @(posedge sclk_i);
        waitCycles(5);

        $display("[TB] streaming");
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(16'(i), 16'(i), 1'b1);
        end
        valid = 1'b0;
        waitCycles(70);

        $display("[TB] random pairs");
        for (int i = 0; i < 12; i++) begin
            waitCycles($urandom_range(0, 70));
            applyStimulus(16'($urandom), 16'($urandom), 1'b0);
        end
        waitCycles(100);

        checkOutput("frames observed", framesSeen > 20, 1'b1);
        checkOutput("pending frames", expQ.size() <= 1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion before 200000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
